// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/exception control for the five-stage Y86-64 pipeline.
// Produces per-stage stall/bubble strobes, holds the sticky RUN/HALT state
// and keeps saturating hazard performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic [3:0]       W_icode_i,
    input  logic             cnt_clr_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_stall_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             set_cc_o,
    output logic             halted_o,
    output logic [2:0]       cpu_stat_o,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] ret_cnt_o
);

    // Y86-64 instruction codes and register ids used by the hazard logic
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    // Status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic load_use;
    logic ret_in;
    logic mispred;
    logic m_exc;
    logic w_exc;

    // Exceptional status: halt, bad address or illegal instruction
    function automatic logic is_exc(input logic [2:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

    // Increment unless already saturated at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Hazard detection terms
    always_comb begin
        load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                   (E_dstM_i != RNONE) &&
                   ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        ret_in   = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        mispred  = (E_icode_i == IJXX) && !e_Cnd_i;
        m_exc    = is_exc(m_stat_i);
        w_exc    = is_exc(W_stat_i);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stage strobes; HALT freezes everything regardless of inputs
    always_comb begin
        state_nxt  = state;
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_stall_o  = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        set_cc_o   = 1'b0;
        case (state)
            ST_RUN: begin
                F_stall_o  = load_use | ret_in;
                D_stall_o  = load_use;
                D_bubble_o = !load_use && (mispred || ret_in);
                E_bubble_o = mispred | load_use;
                M_bubble_o = m_exc | w_exc;
                W_stall_o  = w_exc;
                set_cc_o   = (E_icode_i == IOPQ) && !m_exc && !w_exc;
                if (w_exc) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                E_stall_o  = 1'b1;
                M_bubble_o = 1'b1;
                W_stall_o  = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign halted_o = (state == ST_HALT);

    // Architectural status: captured from W on the edge that halts the machine
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpu_stat_o <= SAOK;
        end else if ((state == ST_RUN) && w_exc) begin
            cpu_stat_o <= W_stat_i;
        end
    end

    // Saturating performance counters; clear wins and works in both states
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_cnt_o     <= '0;
            retire_cnt_o  <= '0;
            lu_cnt_o      <= '0;
            mispred_cnt_o <= '0;
            ret_cnt_o     <= '0;
        end else if (cnt_clr_i) begin
            cyc_cnt_o     <= '0;
            retire_cnt_o  <= '0;
            lu_cnt_o      <= '0;
            mispred_cnt_o <= '0;
            ret_cnt_o     <= '0;
        end else if (state == ST_RUN) begin
            cyc_cnt_o     <= sat_inc(cyc_cnt_o, 1'b1);
            retire_cnt_o  <= sat_inc(retire_cnt_o,
                                     (W_stat_i == SAOK) && (W_icode_i != INOP));
            lu_cnt_o      <= sat_inc(lu_cnt_o, load_use);
            mispred_cnt_o <= sat_inc(mispred_cnt_o, mispred);
            ret_cnt_o     <= sat_inc(ret_cnt_o, ret_in && !load_use && !mispred);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    localparam int unsigned CW = 4;

    localparam logic [3:0] N  = 4'h1;   // INOP
    localparam logic [3:0] MR = 4'h5;   // IMRMOVQ
    localparam logic [3:0] OP = 4'h6;   // IOPQ
    localparam logic [3:0] JX = 4'h7;   // IJXX
    localparam logic [3:0] RT = 4'h9;   // IRET
    localparam logic [3:0] F  = 4'hF;   // RNONE
    localparam logic [2:0] OK = 3'd1;
    localparam logic [2:0] AD = 3'd3;

    localparam logic [7:0] HLT = 8'b1101_0110;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic e_Cnd, cnt_clr;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, D_bubble, E_stall, E_bubble, M_bubble, W_stall, set_cc;
    logic halted;
    logic [2:0] cpu_stat;
    logic [CW-1:0] cyc_cnt, retire_cnt, lu_cnt, mispred_cnt, ret_cnt;

    typedef struct packed {
        logic [7:0]  id;
        logic [7:0]  strb;   // {F_stall,D_stall,D_bubble,E_stall,E_bubble,M_bubble,W_stall,set_cc}
        logic        h;
        logic [2:0]  st;
        logic [19:0] cnt;    // {cyc,retire,lu,mispred,ret}
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .D_icode_i    (D_icode),
        .d_srcA_i     (d_srcA),
        .d_srcB_i     (d_srcB),
        .E_icode_i    (E_icode),
        .E_dstM_i     (E_dstM),
        .e_Cnd_i      (e_Cnd),
        .M_icode_i    (M_icode),
        .m_stat_i     (m_stat),
        .W_stat_i     (W_stat),
        .W_icode_i    (W_icode),
        .cnt_clr_i    (cnt_clr),
        .F_stall_o    (F_stall),
        .D_stall_o    (D_stall),
        .D_bubble_o   (D_bubble),
        .E_stall_o    (E_stall),
        .E_bubble_o   (E_bubble),
        .M_bubble_o   (M_bubble),
        .W_stall_o    (W_stall),
        .set_cc_o     (set_cc),
        .halted_o     (halted),
        .cpu_stat_o   (cpu_stat),
        .cyc_cnt_o    (cyc_cnt),
        .retire_cnt_o (retire_cnt),
        .lu_cnt_o     (lu_cnt),
        .mispred_cnt_o(mispred_cnt),
        .ret_cnt_o    (ret_cnt)
    );

    // Monitor: mid-cycle sample of every output against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [7:0]  a_strb;
            logic [19:0] a_cnt;
            e = exp_q.pop_front();
            a_strb = {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_bubble, W_stall, set_cc};
            a_cnt  = {cyc_cnt, retire_cnt, lu_cnt, mispred_cnt, ret_cnt};
            checks++;
            if (a_strb !== e.strb) begin
                errors++;
                $display("FAIL v%0d strobes got %b want %b", e.id, a_strb, e.strb);
            end
            checks++;
            if (halted !== e.h) begin
                errors++;
                $display("FAIL v%0d halted got %b want %b", e.id, halted, e.h);
            end
            checks++;
            if (cpu_stat !== e.st) begin
                errors++;
                $display("FAIL v%0d cpu_stat got %0d want %0d", e.id, cpu_stat, e.st);
            end
            checks++;
            if (a_cnt !== e.cnt) begin
                errors++;
                $display("FAIL v%0d counters cyc/ret/lu/mis/rt got %h want %h", e.id, a_cnt, e.cnt);
            end
        end
    end

    // Apply one vector just after the edge and queue what it must produce
    task automatic step(input logic [7:0] id, input logic rst,
                        input logic [3:0] d_ic, input logic [3:0] e_ic, input logic [3:0] m_ic,
                        input logic [3:0] dstm, input logic [3:0] sa, input logic [3:0] sb,
                        input logic cnd, input logic [2:0] mst, input logic [2:0] wst,
                        input logic [3:0] wic, input logic clr,
                        input logic [7:0] strb, input logic h, input logic [2:0] st,
                        input logic [3:0] c_cyc, input logic [3:0] c_rtr, input logic [3:0] c_lu,
                        input logic [3:0] c_mis, input logic [3:0] c_rt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        D_icode = d_ic;
        E_icode = e_ic;
        M_icode = m_ic;
        E_dstM  = dstm;
        d_srcA  = sa;
        d_srcB  = sb;
        e_Cnd   = cnd;
        m_stat  = mst;
        W_stat  = wst;
        W_icode = wic;
        cnt_clr = clr;
        e.id   = id;
        e.strb = strb;
        e.h    = h;
        e.st   = st;
        e.cnt  = {c_cyc, c_rtr, c_lu, c_mis, c_rt};
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        D_icode = N; E_icode = N; M_icode = N; W_icode = N;
        E_dstM = F; d_srcA = F; d_srcB = F; e_Cnd = 1'b0;
        m_stat = OK; W_stat = OK; cnt_clr = 1'b0;
        @(posedge clk);
        //    id rst D   E   M   dstM sa sb cnd mst wst wic clr strobes      h st  cyc rtr lu mis rt
        step( 0, 0,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  0,  0,  0, 0,  0);
        step( 1, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  0,  0,  0, 0,  0);
        step( 2, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  1,  0,  0, 0,  0);
        // load-use, then same but with dstM = RNONE
        step( 3, 1,  N,  MR, N,  3,   3, F, 0,  OK, OK, N,  0,  8'b1100_1000, 0, 1,  2,  0,  0, 0,  0);
        step( 4, 1,  N,  MR, N,  F,   3, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  3,  0,  1, 0,  0);
        // mispredict, then taken branch
        step( 5, 1,  N,  JX, N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0010_1000, 0, 1,  4,  0,  1, 0,  0);
        step( 6, 1,  N,  JX, N,  F,   F, F, 1,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  5,  0,  1, 1,  0);
        // ret walks D -> E -> M
        step( 7, 1,  RT, N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b1010_0000, 0, 1,  6,  0,  1, 1,  0);
        step( 8, 1,  N,  RT, N,  F,   F, F, 0,  OK, OK, N,  0,  8'b1010_0000, 0, 1,  7,  0,  1, 1,  1);
        step( 9, 1,  N,  N,  RT, F,   F, F, 0,  OK, OK, N,  0,  8'b1010_0000, 0, 1,  8,  0,  1, 1,  2);
        step(10, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  9,  0,  1, 1,  3);
        // ret in D with load-use on srcB; ret in D with mispredict
        step(11, 1,  RT, MR, N,  4,   F, 4, 0,  OK, OK, N,  0,  8'b1100_1000, 0, 1, 10,  0,  1, 1,  3);
        step(12, 1,  RT, JX, N,  F,   F, F, 0,  OK, OK, N,  0,  8'b1010_1000, 0, 1, 11,  0,  2, 1,  3);
        // condition codes: enabled, then blocked by memory exception
        step(13, 1,  N,  OP, N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0001, 0, 1, 12,  0,  2, 2,  3);
        step(14, 1,  N,  OP, N,  F,   F, F, 0,  AD, OK, N,  0,  8'b0000_0100, 0, 1, 13,  0,  2, 2,  3);
        // retirement and 4-bit cycle counter saturation
        step(15, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, OP, 0,  8'b0000_0000, 0, 1, 14,  0,  2, 2,  3);
        step(16, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1, 15,  1,  2, 2,  3);
        step(17, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1, 15,  1,  2, 2,  3);
        step(18, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1, 15,  1,  2, 2,  3);
        // clear, then resume counting
        step(19, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  1,  8'b0000_0000, 0, 1, 15,  1,  2, 2,  3);
        step(20, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  0,  0,  0, 0,  0);
        step(21, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  1,  0,  0, 0,  0);
        // SADR in W for one cycle: RUN equations during sampling, HALT afterwards
        step(22, 1,  N,  OP, N,  F,   F, F, 0,  OK, AD, MR, 0,  8'b0000_0110, 0, 1,  2,  0,  0, 0,  0);
        step(23, 1,  N,  JX, N,  F,   F, F, 0,  OK, OK, N,  0,  HLT,          1, 3,  3,  0,  0, 0,  0);
        step(24, 1,  N,  OP, N,  F,   F, F, 0,  OK, OK, N,  0,  HLT,          1, 3,  3,  0,  0, 0,  0);
        // clear works while halted
        step(25, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  1,  HLT,          1, 3,  3,  0,  0, 0,  0);
        step(26, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  HLT,          1, 3,  0,  0,  0, 0,  0);
        step(27, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  HLT,          1, 3,  0,  0,  0, 0,  0);
        // async reset mid-HALT, then release
        step(28, 0,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  0,  0,  0, 0,  0);
        step(29, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  0,  0,  0, 0,  0);
        step(30, 1,  N,  N,  N,  F,   F, F, 0,  OK, OK, N,  0,  8'b0000_0000, 0, 1,  1,  0,  0, 0,  0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
